ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Configuration-chain loader for the fabric's switch-block and connection-block memories. It accepts bitstream words over a valid/ready handshake and serialises them MSB-first onto `ccff_head`, gating the chain's shift with `ccff_en`. After the load it rotates the chain once through `ccff_tail` → `ccff_head` and compares a CRC of the returned bits against the CRC of the loaded bits. It sits at the head of a tile's `ccff_head`/`ccff_tail` chain of `mux_tree_tapbuf_*_mem` cells and runs in the `prog_clk` domain.

## Interface
Parameters:
- `CHAIN_LEN`, default 8: number of flops in the attached chain (4 size-2 muxes × 2 bits); must be ≥ 1.
- `WORD_W`, default 8: bitstream word width; must be ≥ 1.
- `CNT_W`, default 16: bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.
- `VERIFY_EN`, default 1: 1 enables the readback rotation, 0 skips it.

Ports:
- `prog_clk` in 1: programming clock; the only clock.
- `prog_reset` in 1: reset, synchronous to `prog_clk`, active-high.
- `start` in 1: begin a load; sampled only in IDLE.
- `word_in` in WORD_W: bitstream word; bit WORD_W-1 is shifted first.
- `word_valid` in 1: `word_in` is valid.
- `word_ready` out 1: the loader accepts a word this cycle.
- `ccff_head` out 1: serial data into the chain.
- `ccff_en` out 1: chain shift enable; the chain captures `ccff_head` at the rising edge ending a cycle with `ccff_en`=1.
- `ccff_tail` in 1: last flop of the chain.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the load, and the verify if enabled, completes.
- `verify_ok` out 1: CRC match; held until the next accepted `start`.
- `verify_err` out 1: CRC mismatch; held until the next accepted `start`.

## Operation
- States: IDLE → FETCH → SHIFT → (FETCH | VERIFY | DONE) → IDLE.
- **IDLE:** `start`=1 clears `bitcnt`, sets `crc`←0xFF, clears `verify_ok`/`verify_err`, and moves to FETCH. `start` in any other state is ignored.
- **FETCH:** `word_ready`=1 and `ccff_en`=0.
  - On `word_valid & word_ready`, the loader latches `word_in` into the shift register and moves to SHIFT.
  - With no valid word the loader waits indefinitely and the chain holds.
- **SHIFT:** one bit per cycle with `ccff_en`=1.
  - `ccff_head` = shift-register MSB (registered output).
  - Each shifted bit updates `crc` (CRC-8, polynomial x^8+x^2+x+1 (0x07), bit-serial, MSB-first, no final XOR). `bitcnt` increments.
  - When WORD_W bits of the word are shifted and `bitcnt` < CHAIN_LEN: go to FETCH.
  - When `bitcnt` reaches CHAIN_LEN: go to VERIFY if VERIFY_EN=1, else DONE. Remaining bits of the current word are discarded.
- **VERIFY:** CHAIN_LEN cycles with `ccff_en`=1.
  - `ccff_head` = `ccff_tail` (combinational path in this state only).
  - `crc2` (init 0xFF) updates with `ccff_tail` each cycle.
  - One full rotation restores the chain contents. The first bit loaded emerges first.
- **DONE:** one cycle. `done`=1 and `ccff_en`=0.
  - With VERIFY_EN=1: `verify_ok`=(`crc2`==`crc`) and `verify_err`=!`verify_ok`.
  - With VERIFY_EN=0: both flags stay 0.
  - Next state is IDLE.
- Total bits shifted in SHIFT is exactly CHAIN_LEN. Words consumed = ceil(CHAIN_LEN/WORD_W).
- **Reset (any state, including mid-operation):** next cycle the state is IDLE. `word_ready`, `ccff_head`, `ccff_en`, `busy`, `done`, `verify_ok`, `verify_err` are all 0, and the counters and CRCs are cleared. Chain contents are undefined; software must reload.

## Timing
- All outputs are registered except `ccff_head` in VERIFY and `word_ready`, which decodes directly from the state register.
- Reset values of all outputs: 0.
- Worked example, `start` sampled at edge 0, `word_valid` held high, CHAIN_LEN=8, WORD_W=8:
  - FETCH in cycle 1; word accepted at edge 1.
  - SHIFT in cycles 2–9.
  - VERIFY in cycles 10–17.
  - `done`=1 in cycle 18, with flags valid from cycle 18.
  - `busy` is high in cycles 1–18.
- General unstalled latency from `start` to `done`: ceil(CHAIN_LEN/WORD_W)·(WORD_W+1) − (discarded bits) + VERIFY_EN·CHAIN_LEN + 1 cycles.
- Each cycle `word_valid` is low in FETCH adds exactly one cycle, with `ccff_en`=0.
- `ccff_en` is never 1 in IDLE, FETCH or DONE.

## Test plan
- CHAIN_LEN=8, WORD_W=8, `word_in`=0xA5, bench chain model attached → `ccff_tail` sequence in VERIFY is 1,0,1,0,0,1,0,1; `done` in cycle 18; `verify_ok`=1; chain model ends holding 0xA5.
- Same load, but the bench flips one chain-model flop at cycle 12 → `verify_err`=1 and `verify_ok`=0 at `done`.
- CHAIN_LEN=12, WORD_W=8, words 0xF0 then 0x3C → bits shifted are 1111_0000_0011; low nibble 0xC discarded; `word_ready` high in exactly 2 cycles; `verify_ok`=1.
- `word_valid` deasserted for 5 cycles before the second word → `ccff_en`=0 during those 5 cycles, `done` 5 cycles later than unstalled, `verify_ok`=1.
- `prog_reset` asserted in cycle 5 of SHIFT → next cycle all outputs 0 and state IDLE; a fresh `start` with 0x3C completes with `verify_ok`=1.
- `start` pulsed in cycle 7 of a running load, plus a VERIFY_EN=0 run → second `start` ignored, only one `done`; with VERIFY_EN=0, `done` in cycle 10 and both flags 0.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Loads a ccff configuration chain MSB-first from handshaked words, then optionally rotates it once to CRC-check the readback.
// Latency: ceil(CHAIN_LEN/WORD_W)*(WORD_W+1) - discarded bits + VERIFY_EN*CHAIN_LEN + 1 cycles from start to done, unstalled.
// Backpressure: word_ready only in FETCH; a missing word stalls the loader with the chain held (ccff_en=0).
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16,
    parameter bit VERIFY_EN = 1'b1
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              verify_ok,
    output logic              verify_err
);

    localparam int WCNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  CHAIN_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WCNT_W-1:0] WORD_LAST  = WCNT_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   shreg;
    logic                head_q;
    logic [CNT_W-1:0]    bitcnt;
    logic [CNT_W-1:0]    vcnt;
    logic [WCNT_W-1:0]   wcnt;
    logic [7:0]          crc;
    logic [7:0]          crc2;
    logic [7:0]          crc2_nxt;

    // CRC-8, poly 0x07, one bit per call, MSB-first, no final XOR.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign crc2_nxt   = crc8_step(crc2, ccff_tail);
    assign word_ready = (state == S_FETCH);
    // During readback the tail is looped straight back so one rotation restores the chain.
    assign ccff_head  = (state == S_VERIFY) ? ccff_tail : head_q;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            head_q     <= 1'b0;
            bitcnt     <= '0;
            vcnt       <= '0;
            wcnt       <= '0;
            crc        <= 8'h00;
            crc2       <= 8'h00;
            ccff_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            verify_ok  <= 1'b0;
            verify_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bitcnt     <= '0;
                        vcnt       <= '0;
                        crc        <= 8'hFF;
                        crc2       <= 8'hFF;
                        verify_ok  <= 1'b0;
                        verify_err <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (word_valid) begin
                        head_q  <= word_in[WORD_W-1];
                        shreg   <= word_in << 1;
                        wcnt    <= '0;
                        ccff_en <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // head_q is the bit the chain captures at this edge.
                    crc    <= crc8_step(crc, head_q);
                    bitcnt <= bitcnt + CNT_W'(1);
                    wcnt   <= wcnt + WCNT_W'(1);
                    head_q <= shreg[WORD_W-1];
                    shreg  <= shreg << 1;
                    if (bitcnt == CHAIN_LAST) begin
                        if (VERIFY_EN) begin
                            state <= S_VERIFY;
                        end else begin
                            ccff_en <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end
                    end else if (wcnt == WORD_LAST) begin
                        ccff_en <= 1'b0;
                        state   <= S_FETCH;
                    end
                end
                S_VERIFY: begin
                    crc2 <= crc2_nxt;
                    vcnt <= vcnt + CNT_W'(1);
                    if (vcnt == CHAIN_LAST) begin
                        ccff_en    <= 1'b0;
                        done       <= 1'b1;
                        verify_ok  <= (crc2_nxt == crc);
                        verify_err <= (crc2_nxt != crc);
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: three instances (8/8 verify, 12/8 verify, 8/8 no verify) each driving a chain model.
module tb_ccff_chain_loader;

    logic       prog_clk = 1'b0;
    logic       prog_reset;
    logic       start_a, start_b, start_c;
    logic [7:0] word_in;
    logic       word_valid;

    logic ready_a, head_a, en_a, busy_a, done_a, ok_a, err_a;
    logic ready_b, head_b, en_b, busy_b, done_b, ok_b, err_b;
    logic ready_c, head_c, en_c, busy_c, done_c, ok_c, err_c;

    logic [7:0]  chain_a;
    logic [11:0] chain_b;
    logic [7:0]  chain_c;
    logic [7:0]  flip_a;

    int checks = 0;
    int errors = 0;
    int cur_sel = 0;

    logic m_ready, m_head, m_en, m_busy, m_done, m_ok, m_err, m_tail;
    logic [11:0] m_chain;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .CNT_W(16), .VERIFY_EN(1'b1)) u_a (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_a),
        .word_in(word_in), .word_valid(word_valid), .word_ready(ready_a),
        .ccff_head(head_a), .ccff_en(en_a), .ccff_tail(chain_a[7]),
        .busy(busy_a), .done(done_a), .verify_ok(ok_a), .verify_err(err_a));

    ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8), .CNT_W(16), .VERIFY_EN(1'b1)) u_b (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_b),
        .word_in(word_in), .word_valid(word_valid), .word_ready(ready_b),
        .ccff_head(head_b), .ccff_en(en_b), .ccff_tail(chain_b[11]),
        .busy(busy_b), .done(done_b), .verify_ok(ok_b), .verify_err(err_b));

    ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .CNT_W(16), .VERIFY_EN(1'b0)) u_c (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_c),
        .word_in(word_in), .word_valid(word_valid), .word_ready(ready_c),
        .ccff_head(head_c), .ccff_en(en_c), .ccff_tail(chain_c[7]),
        .busy(busy_c), .done(done_c), .verify_ok(ok_c), .verify_err(err_c));

    // Chain models: shift toward the tail when enabled; flip_a injects a bit error into chain A.
    always @(posedge prog_clk) begin
        if (prog_reset) begin
            chain_a <= 8'h00;
            chain_b <= 12'h000;
            chain_c <= 8'h00;
        end else begin
            chain_a <= (en_a ? {chain_a[6:0], head_a} : chain_a) ^ flip_a;
            chain_b <= en_b ? {chain_b[10:0], head_b} : chain_b;
            chain_c <= en_c ? {chain_c[6:0], head_c} : chain_c;
        end
    end

    always_comb begin
        m_ready = ready_a; m_head = head_a; m_en = en_a; m_busy = busy_a;
        m_done  = done_a;  m_ok   = ok_a;   m_err = err_a; m_tail = chain_a[7];
        m_chain = {4'h0, chain_a};
        case (cur_sel)
            1: begin
                m_ready = ready_b; m_head = head_b; m_en = en_b; m_busy = busy_b;
                m_done  = done_b;  m_ok   = ok_b;   m_err = err_b; m_tail = chain_b[11];
                m_chain = chain_b;
            end
            2: begin
                m_ready = ready_c; m_head = head_c; m_en = en_c; m_busy = busy_c;
                m_done  = done_c;  m_ok   = ok_c;   m_err = err_c; m_tail = chain_c[7];
                m_chain = {4'h0, chain_c};
            end
            default: ;
        endcase
    end

    typedef struct {
        int         sel;
        logic [7:0] w0;
        logic [7:0] w1;
        int         stall;
        int         flip_cyc;
        int         start2_cyc;
        int         exp_done;
        int         exp_rdy;
        int         exp_en;
        logic       exp_ok;
        logic       exp_err;
        logic       chk_chain;
        logic [11:0] exp_chain;
        logic       chk_tail;
        logic [7:0] exp_tail;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic set_start(input int sel, input logic v);
        start_a = (sel == 0) ? v : 1'b0;
        start_b = (sel == 1) ? v : 1'b0;
        start_c = (sel == 2) ? v : 1'b0;
    endtask

    // One load on the selected instance; cycle 1 is the cycle after start is sampled.
    task automatic run_load(input int sel, input logic [7:0] w0, input logic [7:0] w1,
                            input int stall, input int flip_cyc, input int start2_cyc,
                            output int done_cyc, output int done_cnt, output int rdy_cnt,
                            output int en_cnt, output int busy_cnt, output int en_bad,
                            output logic ok, output logic err, output logic [7:0] tail_seq);
        int widx;
        int sl;
        int cyc;
        done_cyc = -1; done_cnt = 0; rdy_cnt = 0; en_cnt = 0; busy_cnt = 0; en_bad = 0;
        ok = 1'bx; err = 1'bx; tail_seq = 8'h00;
        widx = 0; sl = stall;
        cur_sel = sel;
        word_valid = 1'b0;
        set_start(sel, 1'b1);
        step();
        cyc = 1;
        for (int i = 0; i < 60; i++) begin
            set_start(sel, cyc == start2_cyc);
            flip_a = (sel == 0 && cyc == flip_cyc) ? 8'h80 : 8'h00;
            if (m_ready && widx == 1 && sl > 0) begin
                word_valid = 1'b0;
                sl--;
            end else begin
                word_valid = 1'b1;
                word_in = (widx == 0) ? w0 : w1;
                if (m_ready) widx++;
            end
            #1;
            if (m_ready) rdy_cnt++;
            if (m_en) en_cnt++;
            if (m_busy) busy_cnt++;
            if (m_en && (m_ready || m_done || !m_busy)) en_bad++;
            if (m_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    ok = m_ok;
                    err = m_err;
                end
            end
            if (cyc >= 10 && cyc <= 17) tail_seq[17 - cyc] = m_tail;
            step();
            cyc++;
        end
        set_start(sel, 1'b0);
        flip_a = 8'h00;
        word_valid = 1'b0;
    endtask

    initial begin
        int d_cyc, d_cnt, r_cnt, e_cnt, b_cnt, e_bad;
        logic r_ok, r_err;
        logic [7:0] t_seq;

        prog_reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        word_in = 8'h00; word_valid = 1'b0; flip_a = 8'h00;

        //            sel  w0     w1   stall flip st2 done rdy en  ok    err   chkc  chain    chkt  tail
        vecs[0] = '{0, 8'hA5, 8'h00, 0, 0,  0, 18, 1, 16, 1'b1, 1'b0, 1'b1, 12'h0A5, 1'b1, 8'hA5};
        vecs[1] = '{0, 8'hA5, 8'h00, 0, 12, 0, 18, 1, 16, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 8'h00};
        vecs[2] = '{0, 8'h3C, 8'h00, 0, 0,  0, 18, 1, 16, 1'b1, 1'b0, 1'b1, 12'h03C, 1'b1, 8'h3C};
        vecs[3] = '{1, 8'hF0, 8'h3C, 0, 0,  0, 27, 2, 24, 1'b1, 1'b0, 1'b1, 12'hF03, 1'b0, 8'h00};
        vecs[4] = '{1, 8'hF0, 8'h3C, 5, 0,  0, 32, 7, 24, 1'b1, 1'b0, 1'b1, 12'hF03, 1'b0, 8'h00};
        vecs[5] = '{2, 8'hA5, 8'h00, 0, 0,  7, 10, 1, 8,  1'b0, 1'b0, 1'b1, 12'h0A5, 1'b0, 8'h00};
        vecs[6] = '{0, 8'h00, 8'h00, 0, 0,  7, 18, 1, 16, 1'b1, 1'b0, 1'b1, 12'h000, 1'b1, 8'h00};
        vecs[7] = '{1, 8'hFF, 8'h00, 0, 0,  0, 27, 2, 24, 1'b1, 1'b0, 1'b1, 12'hFF0, 1'b0, 8'h00};
        vecs[8] = '{2, 8'h3C, 8'h00, 0, 0,  0, 10, 1, 8,  1'b0, 1'b0, 1'b1, 12'h03C, 1'b0, 8'h00};

        repeat (3) step();
        chk("reset_outs_a", 32'({ready_a, head_a, en_a, busy_a, done_a, ok_a, err_a}), 32'd0);
        chk("reset_outs_b", 32'({ready_b, head_b, en_b, busy_b, done_b, ok_b, err_b}), 32'd0);
        chk("reset_outs_c", 32'({ready_c, head_c, en_c, busy_c, done_c, ok_c, err_c}), 32'd0);
        prog_reset = 1'b0;
        step();

        for (int v = 0; v < 9; v++) begin
            run_load(vecs[v].sel, vecs[v].w0, vecs[v].w1, vecs[v].stall, vecs[v].flip_cyc,
                     vecs[v].start2_cyc, d_cyc, d_cnt, r_cnt, e_cnt, b_cnt, e_bad, r_ok, r_err, t_seq);
            chk($sformatf("v%0d_done_cycle", v), 32'(d_cyc), 32'(vecs[v].exp_done));
            chk($sformatf("v%0d_done_pulses", v), 32'(d_cnt), 32'd1);
            chk($sformatf("v%0d_ready_cycles", v), 32'(r_cnt), 32'(vecs[v].exp_rdy));
            chk($sformatf("v%0d_en_cycles", v), 32'(e_cnt), 32'(vecs[v].exp_en));
            chk($sformatf("v%0d_busy_cycles", v), 32'(b_cnt), 32'(vecs[v].exp_done));
            chk($sformatf("v%0d_en_outside_load", v), 32'(e_bad), 32'd0);
            chk($sformatf("v%0d_verify_ok", v), 32'(r_ok), 32'(vecs[v].exp_ok));
            chk($sformatf("v%0d_verify_err", v), 32'(r_err), 32'(vecs[v].exp_err));
            if (vecs[v].chk_chain) chk($sformatf("v%0d_chain", v), 32'(m_chain), 32'(vecs[v].exp_chain));
            if (vecs[v].chk_tail) chk($sformatf("v%0d_tail_seq", v), 32'(t_seq), 32'(vecs[v].exp_tail));
        end

        // Reset in the fifth SHIFT cycle (cycle 6) of an 8-bit load.
        cur_sel = 0;
        word_valid = 1'b1;
        word_in = 8'hA5;
        set_start(0, 1'b1);
        step();
        set_start(0, 1'b0);
        repeat (5) step();
        chk("pre_reset_busy_en", 32'({busy_a, en_a}), 32'd3);
        prog_reset = 1'b1;
        step();
        prog_reset = 1'b0;
        chk("reset_mid_shift_outs", 32'({ready_a, head_a, en_a, busy_a, done_a, ok_a, err_a}), 32'd0);
        word_valid = 1'b0;
        step();
        chk("reset_stays_idle", 32'({ready_a, busy_a, en_a}), 32'd0);
        run_load(0, 8'h3C, 8'h00, 0, 0, 0, d_cyc, d_cnt, r_cnt, e_cnt, b_cnt, e_bad, r_ok, r_err, t_seq);
        chk("reload_done_cycle", 32'(d_cyc), 32'd18);
        chk("reload_verify_ok", 32'(r_ok), 32'd1);
        chk("reload_chain", 32'(m_chain), 32'h3C);

        // Flags hold after done and are cleared by reset.
        chk("ok_held_after_done", 32'(ok_a), 32'd1);
        prog_reset = 1'b1;
        step();
        prog_reset = 1'b0;
        chk("reset_clears_flags", 32'({ok_a, err_a, busy_a}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
